// File: rtl/uv_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uv_stack_pkg
// Description : Shared constants for the pointer-addressed LIFO storage and
//               its push/pop front-end (uv_stack_ctrl).
//               DEF_DAT_WIDTH / DEF_PTR_WIDTH : default entry and pointer width
//               UDLY                          : delay constant used by storage
// Revision    : 1.0 - initial release
// ============================================================================
package uv_stack_pkg;

    localparam int DEF_DAT_WIDTH = 32;
    localparam int DEF_PTR_WIDTH = 3;

    // Unit delay applied by the storage model on its registered outputs.
    localparam int UDLY = 1;

endpackage : uv_stack_pkg
`default_nettype wire

// File: rtl/uv_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uv_stack_ctrl
// Description : Push/pop front-end for the pointer-addressed LIFO storage.
//               Tracks top-of-stack pointer and occupancy, drives the storage
//               write/read/clear channels and returns popped data with the
//               storage read latency (ZERO_RDLY).
// Ports       : clk, rst_n (async, active-low)
//               push_vld/push_rdy/push_dat  - push request handshake
//               pop_vld/pop_rdy             - pop request handshake
//               pop_rsp_vld/pop_rsp_dat     - popped data (no backpressure)
//               clr                         - synchronous flush
//               st_wr/st_wr_ptr/st_wr_dat   - storage write channel
//               st_rd/st_rd_ptr/st_rd_dat   - storage read channel
//               st_clr                      - storage clear (equals clr)
//               len/full/empty              - registered occupancy status
//               ovf                         - oldest-entry overwrite pulse
// Macro       : UV_STACK_CTRL_OVWR_EN - push while full overwrites the oldest
//               entry instead of being backpressured.
// Revision    : 1.0 - initial release
// ============================================================================
module uv_stack_ctrl
    import uv_stack_pkg::*;
#(
    parameter int DAT_WIDTH = DEF_DAT_WIDTH,
    parameter int PTR_WIDTH = DEF_PTR_WIDTH,
    parameter bit ZERO_RDLY = 1'b1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_vld,
    output logic                 push_rdy,
    input  logic [DAT_WIDTH-1:0] push_dat,
    input  logic                 pop_vld,
    output logic                 pop_rdy,
    output logic                 pop_rsp_vld,
    output logic [DAT_WIDTH-1:0] pop_rsp_dat,
    input  logic                 clr,
    output logic                 st_wr,
    output logic [PTR_WIDTH-1:0] st_wr_ptr,
    output logic [DAT_WIDTH-1:0] st_wr_dat,
    output logic                 st_rd,
    output logic [PTR_WIDTH-1:0] st_rd_ptr,
    input  logic [DAT_WIDTH-1:0] st_rd_dat,
    output logic                 st_clr,
    output logic [PTR_WIDTH:0]   len,
    output logic                 full,
    output logic                 empty,
    output logic                 ovf
);

    localparam logic [PTR_WIDTH:0]   c_depth   = (PTR_WIDTH+1)'(1) << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0]   c_cnt_one = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] c_ptr_one = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0] r_tp;
    logic [PTR_WIDTH:0]   r_cnt;
    logic                 r_full;
    logic                 r_empty;

    logic [PTR_WIDTH-1:0] w_tp_m1;
    logic [PTR_WIDTH-1:0] w_tp_nxt;
    logic [PTR_WIDTH:0]   w_cnt_nxt;
    logic                 w_push_acc;
    logic                 w_pop_acc;

    // ------------------------------------------------------------------
    // Handshakes. A simultaneous pop frees the top slot, so a full stack
    // can still take a push when it is paired with a pop (replace).
    // ------------------------------------------------------------------
    assign pop_rdy = !r_empty && !clr;

`ifdef UV_STACK_CTRL_OVWR_EN
    assign push_rdy = !clr;
    assign ovf      = w_push_acc && !w_pop_acc && r_full;
`else
    assign push_rdy = !clr && (!r_full || pop_vld);
    assign ovf      = 1'b0;
`endif

    assign w_push_acc = push_vld && push_rdy;
    assign w_pop_acc  = pop_vld && pop_rdy;
    assign w_tp_m1    = r_tp - c_ptr_one;

    // ------------------------------------------------------------------
    // Storage channels. On replace both ports address the current top;
    // the storage resolves read-before-write so the old top is returned.
    // ------------------------------------------------------------------
    assign st_wr     = w_push_acc;
    assign st_wr_ptr = w_pop_acc ? w_tp_m1 : r_tp;
    assign st_wr_dat = push_dat;
    assign st_rd     = w_pop_acc;
    assign st_rd_ptr = w_tp_m1;
    assign st_clr    = clr;

    // ------------------------------------------------------------------
    // Pointer / occupancy update
    // ------------------------------------------------------------------
    always_comb begin
        w_tp_nxt  = r_tp;
        w_cnt_nxt = r_cnt;
        if (clr) begin
            w_tp_nxt  = '0;
            w_cnt_nxt = '0;
        end else if (w_push_acc && !w_pop_acc) begin
            w_tp_nxt = r_tp + c_ptr_one;
            // Overwrite while full keeps occupancy pinned at depth.
            if (!r_full) begin
                w_cnt_nxt = r_cnt + c_cnt_one;
            end
        end else if (w_pop_acc && !w_push_acc) begin
            w_tp_nxt  = w_tp_m1;
            w_cnt_nxt = r_cnt - c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tp    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_tp    <= w_tp_nxt;
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == c_depth);
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    assign len   = r_cnt;
    assign full  = r_full;
    assign empty = r_empty;

    // ------------------------------------------------------------------
    // Pop response. A response already in flight survives clr (clr only
    // blocks new accepts) but is dropped by reset.
    // ------------------------------------------------------------------
    generate
        if (ZERO_RDLY) begin : g_rdly_zero
            assign pop_rsp_vld = w_pop_acc;
        end else begin : g_rdly_one
            logic r_rsp_vld;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rsp_vld <= 1'b0;
                end else begin
                    r_rsp_vld <= w_pop_acc;
                end
            end
            assign pop_rsp_vld = r_rsp_vld;
        end
    endgenerate

    // Gate the data so it reads as zero whenever no response is presented.
    assign pop_rsp_dat = pop_rsp_vld ? st_rd_dat : '0;

endmodule : uv_stack_ctrl
`default_nettype wire

// File: tb/tb_uv_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uv_stack_ctrl
// Description : Directed self-checking bench for uv_stack_ctrl. Two instances
//               (ZERO_RDLY=0 and ZERO_RDLY=1) share one stimulus stream, each
//               with its own behavioural storage array (read-before-write).
// Macro       : UV_STACK_CTRL_OVWR_EN selects the overwrite expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uv_stack_ctrl;

    localparam int DW = 32;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push_vld;
    logic [DW-1:0] push_dat;
    logic          pop_vld;
    logic          clr;

    // Per-instance outputs, index 0 -> ZERO_RDLY=0, index 1 -> ZERO_RDLY=1
    logic          push_rdy   [2];
    logic          pop_rdy    [2];
    logic          rsp_vld    [2];
    logic [DW-1:0] rsp_dat    [2];
    logic          st_wr      [2];
    logic [PW-1:0] st_wr_ptr  [2];
    logic [DW-1:0] st_wr_dat  [2];
    logic          st_rd      [2];
    logic [PW-1:0] st_rd_ptr  [2];
    logic [DW-1:0] st_rd_dat  [2];
    logic          st_clr     [2];
    logic [PW:0]   len        [2];
    logic          full       [2];
    logic          empty      [2];
    logic          ovf        [2];

    logic [DW-1:0] mem0 [8];
    logic [DW-1:0] mem1 [8];
    logic [DW-1:0] rd_q0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    // Snapshots of in-cycle outputs, taken at the falling edge
    logic s_push_rdy [2];
    logic s_pop_rdy  [2];
    logic s_st_wr    [2];
    logic s_st_rd    [2];
    logic s_st_clr   [2];
    logic s_ovf      [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uv_stack_ctrl #(.DAT_WIDTH(DW), .PTR_WIDTH(PW), .ZERO_RDLY(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .push_vld(push_vld), .push_rdy(push_rdy[0]), .push_dat(push_dat),
        .pop_vld(pop_vld), .pop_rdy(pop_rdy[0]),
        .pop_rsp_vld(rsp_vld[0]), .pop_rsp_dat(rsp_dat[0]),
        .clr(clr),
        .st_wr(st_wr[0]), .st_wr_ptr(st_wr_ptr[0]), .st_wr_dat(st_wr_dat[0]),
        .st_rd(st_rd[0]), .st_rd_ptr(st_rd_ptr[0]), .st_rd_dat(st_rd_dat[0]),
        .st_clr(st_clr[0]), .len(len[0]), .full(full[0]), .empty(empty[0]),
        .ovf(ovf[0])
    );

    uv_stack_ctrl #(.DAT_WIDTH(DW), .PTR_WIDTH(PW), .ZERO_RDLY(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .push_vld(push_vld), .push_rdy(push_rdy[1]), .push_dat(push_dat),
        .pop_vld(pop_vld), .pop_rdy(pop_rdy[1]),
        .pop_rsp_vld(rsp_vld[1]), .pop_rsp_dat(rsp_dat[1]),
        .clr(clr),
        .st_wr(st_wr[1]), .st_wr_ptr(st_wr_ptr[1]), .st_wr_dat(st_wr_dat[1]),
        .st_rd(st_rd[1]), .st_rd_ptr(st_rd_ptr[1]), .st_rd_dat(st_rd_dat[1]),
        .st_clr(st_clr[1]), .len(len[1]), .full(full[1]), .empty(empty[1]),
        .ovf(ovf[1])
    );

    // Storage for ZERO_RDLY=0: registered read, old data on read/write collision
    always @(posedge clk) begin
        if (st_wr[0]) mem0[st_wr_ptr[0]] <= st_wr_dat[0];
        if (st_rd[0]) rd_q0 <= mem0[st_rd_ptr[0]];
    end
    assign st_rd_dat[0] = rd_q0;

    // Storage for ZERO_RDLY=1: combinational read, write at the clock edge
    always @(posedge clk) begin
        if (st_wr[1]) mem1[st_wr_ptr[1]] <= st_wr_dat[1];
    end
    assign st_rd_dat[1] = mem1[st_rd_ptr[1]];

    // Response collectors
    always @(negedge clk) begin
        if (rst_n && rsp_vld[0]) q0.push_back(rsp_dat[0]);
        if (rst_n && rsp_vld[1]) q1.push_back(rsp_dat[1]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; in-cycle outputs are snapshotted.
    task automatic cyc(input logic pv, input logic [DW-1:0] pd, input logic ppv, input logic c);
        push_vld = pv;
        push_dat = pd;
        pop_vld  = ppv;
        clr      = c;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            s_push_rdy[i] = push_rdy[i];
            s_pop_rdy[i]  = pop_rdy[i];
            s_st_wr[i]    = st_wr[i];
            s_st_rd[i]    = st_rd[i];
            s_st_clr[i]   = st_clr[i];
            s_ovf[i]      = ovf[i];
        end
        @(posedge clk);
        #1;
        push_vld = 1'b0;
        pop_vld  = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic exp_rsp(input string tag, input logic [DW-1:0] exp);
        logic [DW-1:0] v0;
        logic [DW-1:0] v1;
        v0 = 'x;
        v1 = 'x;
        if (q0.size() > 0) v0 = q0.pop_front();
        if (q1.size() > 0) v1 = q1.pop_front();
        chk({tag, "_rd0"}, v0, exp);
        chk({tag, "_rd1"}, v1, exp);
    endtask

    task automatic chk_both(input string tag, input logic [31:0] o0, input logic [31:0] o1,
                            input logic [31:0] exp);
        chk({tag, "_rd0"}, o0, exp);
        chk({tag, "_rd1"}, o1, exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        push_vld = 1'b0;
        push_dat = '0;
        pop_vld  = 1'b0;
        clr      = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- reset values ----------------
        chk_both("rst_len",   32'(len[0]),   32'(len[1]),   0);
        chk_both("rst_empty", 32'(empty[0]), 32'(empty[1]), 1);
        chk_both("rst_full",  32'(full[0]),  32'(full[1]),  0);
        chk_both("rst_vld",   32'(rsp_vld[0]), 32'(rsp_vld[1]), 0);
        chk_both("rst_dat",   rsp_dat[0], rsp_dat[1], 0);
        chk_both("rst_ovf",   32'(ovf[0]),   32'(ovf[1]),   0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // ---------------- LIFO ordering ----------------
        cyc(1, 32'h11, 0, 0);
        cyc(1, 32'h22, 0, 0);
        cyc(1, 32'h33, 0, 0);
        chk_both("lifo_len3", 32'(len[0]), 32'(len[1]), 3);
        cyc(0, 0, 1, 0);
        chk_both("lifo_len2", 32'(len[0]), 32'(len[1]), 2);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        exp_rsp("lifo_r0", 32'h33);
        exp_rsp("lifo_r1", 32'h22);
        exp_rsp("lifo_r2", 32'h11);
        chk_both("lifo_len0",  32'(len[0]),   32'(len[1]),   0);
        chk_both("lifo_empty", 32'(empty[0]), 32'(empty[1]), 1);

        // ---------------- fill to full ----------------
        for (int i = 0; i < 8; i++) cyc(1, DW'(i), 0, 0);
        chk_both("fill_full", 32'(full[0]), 32'(full[1]), 1);
        chk_both("fill_len",  32'(len[0]),  32'(len[1]),  8);
        cyc(1, 32'h8, 0, 0);
        chk_both("ovw_len", 32'(len[0]), 32'(len[1]), 8);
`ifdef UV_STACK_CTRL_OVWR_EN
        chk_both("ovw_rdy", 32'(s_push_rdy[0]), 32'(s_push_rdy[1]), 1);
        chk_both("ovw_ovf", 32'(s_ovf[0]),      32'(s_ovf[1]),      1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        for (int i = 8; i >= 1; i--) exp_rsp("ovw_pop", DW'(i));
`else
        chk_both("bp_rdy", 32'(s_push_rdy[0]), 32'(s_push_rdy[1]), 0);
        chk_both("bp_wr",  32'(s_st_wr[0]),    32'(s_st_wr[1]),    0);
        chk_both("bp_ovf", 32'(s_ovf[0]),      32'(s_ovf[1]),      0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        for (int i = 7; i >= 0; i--) exp_rsp("bp_pop", DW'(i));
`endif
        chk_both("drain_len", 32'(len[0]), 32'(len[1]), 0);

        // ---------------- pop while empty ----------------
        cyc(0, 0, 1, 0);
        chk_both("epop_rdy", 32'(s_pop_rdy[0]), 32'(s_pop_rdy[1]), 0);
        chk_both("epop_rd",  32'(s_st_rd[0]),   32'(s_st_rd[1]),   0);
        cyc(0, 0, 0, 0);
        chk_both("epop_norsp", q0.size(), q1.size(), 0);

        // ---------------- replace (push + pop) ----------------
        cyc(1, 32'hA, 0, 0);
        cyc(1, 32'hB, 0, 0);
        cyc(1, 32'hC, 1, 0);
        chk_both("rep_prdy", 32'(s_push_rdy[0]), 32'(s_push_rdy[1]), 1);
        chk_both("rep_len",  32'(len[0]), 32'(len[1]), 2);
        cyc(0, 0, 0, 0);
        exp_rsp("rep_old", 32'hB);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        exp_rsp("rep_new", 32'hC);
        exp_rsp("rep_bot", 32'hA);

        // ---------------- clr blocks push ----------------
        cyc(1, 32'h5, 0, 0);
        cyc(1, 32'h6, 0, 0);
        cyc(1, 32'h7, 0, 1);
        chk_both("clr_prdy", 32'(s_push_rdy[0]), 32'(s_push_rdy[1]), 0);
        chk_both("clr_stclr", 32'(s_st_clr[0]), 32'(s_st_clr[1]), 1);
        chk_both("clr_wr",   32'(s_st_wr[0]),   32'(s_st_wr[1]),   0);
        chk_both("clr_len",  32'(len[0]), 32'(len[1]), 0);
        chk_both("clr_empty", 32'(empty[0]), 32'(empty[1]), 1);

        // ---------------- in-flight response survives clr ----------------
        cyc(1, 32'h9, 0, 0);
        cyc(1, 32'h8, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        exp_rsp("clr_fly", 32'h8);
        chk_both("clr_fly_len", 32'(len[0]), 32'(len[1]), 0);

        // ---------------- reset during a pending response ----------------
        cyc(1, 32'h1, 0, 0);
        cyc(0, 0, 1, 0);          // accepted; ZERO_RDLY=0 response now pending
        rst_n = 1'b0;
        #1;
        chk_both("arst_vld", 32'(rsp_vld[0]), 32'(rsp_vld[1]), 0);
        chk_both("arst_dat", rsp_dat[0], rsp_dat[1], 0);
        chk_both("arst_empty", 32'(empty[0]), 32'(empty[1]), 1);
        repeat (2) @(negedge clk);
        chk_both("arst_hold_len", 32'(len[0]), 32'(len[1]), 0);
        chk_both("arst_hold_vld", 32'(rsp_vld[0]), 32'(rsp_vld[1]), 0);
        chk("arst_q1", q1.size(), 1);  // zero-latency response was delivered
        chk("arst_q0", q0.size(), 0);  // delayed response was discarded
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_both("post_rst_norsp", q0.size(), q1.size(), 0);
        chk_both("post_rst_len", 32'(len[0]), 32'(len[1]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uv_stack_ctrl
`default_nettype wire
